// File: rtl/hotspot_pkg.sv
// Shared Q10.22 constants, window lane map, pipeline records and fixed-point helpers.
package hotspot_pkg;

  localparam int unsigned Q_INT_WIDTH   = 10;
  localparam int unsigned Q_FLOAT_WIDTH = 22;
  localparam logic [31:0] Q_ONE         = 32'(1) << Q_FLOAT_WIDTH;

  localparam int unsigned LANE_C = 0;
  localparam int unsigned LANE_N = 1;
  localparam int unsigned LANE_S = 2;
  localparam int unsigned LANE_W = 3;
  localparam int unsigned LANE_E = 4;

  localparam logic [31:0] SAT_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] SAT_MIN = 32'h80000000;

  // Stage-1 record: neighbour differences plus the centre and power operands.
  typedef struct packed {
    logic signed [33:0] dns;
    logic signed [33:0] dew;
    logic signed [32:0] da;
    logic signed [31:0] c;
    logic signed [31:0] p;
  } s1_t;

  // Stage-2 record: accumulated heat flow plus the centre temperature.
  typedef struct packed {
    logic signed [39:0] sum;
    logic signed [31:0] c;
  } s2_t;

  // Arithmetic shift of a full-width product back into Q format (floor rounding).
  function automatic logic signed [127:0] qshift(input logic signed [127:0] prod,
                                                 input int unsigned sh);
    return prod >>> sh;
  endfunction

  // Clamp a wide signed result into the 32-bit Q10.22 range.
  function automatic logic [31:0] sat32(input logic signed [63:0] x);
    if (x > 64'sh000000007FFFFFFF) return SAT_MAX;
    if (x < -64'sh0000000080000000) return SAT_MIN;
    return x[31:0];
  endfunction

endpackage

// File: rtl/hotspot_qmul.sv
// Signed full-precision multiply followed by a Q-format arithmetic right shift.
module hotspot_qmul
  import hotspot_pkg::*;
#(
  parameter int unsigned A_W   = 32,
  parameter int unsigned B_W   = 32,
  parameter int unsigned SHIFT = Q_FLOAT_WIDTH
) (
  input  logic signed [A_W-1:0]           a,
  input  logic signed [B_W-1:0]           b,
  output logic signed [A_W+B_W-SHIFT-1:0] p
);

  localparam int unsigned FULL_W = A_W + B_W;
  localparam int unsigned OUT_W  = A_W + B_W - SHIFT;

  logic signed [FULL_W-1:0] full;

  assign full = a * b;
  assign p    = OUT_W'(qshift(128'(full), SHIFT));

endmodule

// File: rtl/hotspot_update.sv
// HotSpot2D cell update: joins temperature window and power streams, three-stage
// stall-all pipeline, saturated Q10.22 result with frame-end marker.
module hotspot_update
  import hotspot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INT_WIDTH   = Q_INT_WIDTH,
  parameter int unsigned FLOAT_WIDTH = Q_FLOAT_WIDTH,
  parameter int unsigned SIZE        = 512,
  parameter logic [31:0] CAP         = 32'h00400000,
  parameter logic [31:0] RX_INV      = 32'h00000000,
  parameter logic [31:0] RY_INV      = 32'h00000000,
  parameter logic [31:0] RZ_INV      = 32'h00000000,
  parameter logic [31:0] AMB         = 32'h14000000
) (
  input  logic                    aclk,
  input  logic                    axi_resetn,
  input  logic [DATA_WIDTH*5-1:0] s_axis_temp_data,
  input  logic                    s_axis_temp_valid,
  output logic                    s_axis_temp_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_power_data,
  input  logic                    s_axis_power_valid,
  output logic                    s_axis_power_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_temp_data,
  output logic                    m_axis_temp_valid,
  input  logic                    m_axis_temp_ready,
  output logic                    m_axis_temp_last
);

  if (INT_WIDTH + FLOAT_WIDTH != DATA_WIDTH) begin : g_qfmt_check
    $error("hotspot_update: INT_WIDTH + FLOAT_WIDTH must equal DATA_WIDTH");
  end

  localparam int unsigned FRAME    = SIZE * SIZE;
  localparam int unsigned CNT_W    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam int unsigned MD_W     = 34 + 32 - FLOAT_WIDTH;
  localparam int unsigned MA_W     = 33 + 32 - FLOAT_WIDTH;
  localparam int unsigned MC_W     = 40 + 32 - FLOAT_WIDTH;

  logic                    adv;
  logic                    join_ok;
  logic                    v1, v2, v3;
  s1_t                     s1_d, s1_q;
  s2_t                     s2_d, s2_q;
  logic [DATA_WIDTH-1:0]   out_d, out_q;
  logic [CNT_W-1:0]        cnt;
  logic signed [31:0]      lane_c, lane_n, lane_s, lane_w, lane_e;
  logic signed [MD_W-1:0]  m_ns, m_ew;
  logic signed [MA_W-1:0]  m_a;
  logic signed [MC_W-1:0]  m_cap;

  assign lane_c = s_axis_temp_data[LANE_C*DATA_WIDTH +: DATA_WIDTH];
  assign lane_n = s_axis_temp_data[LANE_N*DATA_WIDTH +: DATA_WIDTH];
  assign lane_s = s_axis_temp_data[LANE_S*DATA_WIDTH +: DATA_WIDTH];
  assign lane_w = s_axis_temp_data[LANE_W*DATA_WIDTH +: DATA_WIDTH];
  assign lane_e = s_axis_temp_data[LANE_E*DATA_WIDTH +: DATA_WIDTH];

  // Whole pipeline moves together; a beat is taken only when both streams offer one.
  assign adv                = ~v3 | m_axis_temp_ready;
  assign join_ok            = axi_resetn & adv & s_axis_temp_valid & s_axis_power_valid;
  assign s_axis_temp_ready  = join_ok;
  assign s_axis_power_ready = join_ok;

  // Stage-1 operands: Laplacian terms per axis and distance to ambient.
  always_comb begin
    s1_d     = '0;
    s1_d.dns = 34'(lane_n) + 34'(lane_s) - (34'(lane_c) <<< 1);
    s1_d.dew = 34'(lane_w) + 34'(lane_e) - (34'(lane_c) <<< 1);
    s1_d.da  = 33'($signed(AMB)) - 33'(lane_c);
    s1_d.c   = lane_c;
    s1_d.p   = $signed(s_axis_power_data);
  end

  hotspot_qmul #(.A_W(34), .B_W(32), .SHIFT(FLOAT_WIDTH)) u_mul_ns (
    .a(s1_q.dns), .b(RY_INV), .p(m_ns)
  );
  hotspot_qmul #(.A_W(34), .B_W(32), .SHIFT(FLOAT_WIDTH)) u_mul_ew (
    .a(s1_q.dew), .b(RX_INV), .p(m_ew)
  );
  hotspot_qmul #(.A_W(33), .B_W(32), .SHIFT(FLOAT_WIDTH)) u_mul_a (
    .a(s1_q.da), .b(RZ_INV), .p(m_a)
  );

  // Stage-2 accumulation, wrapped to 40 bits.
  always_comb begin
    s2_d     = '0;
    s2_d.sum = 40'($signed(s1_q.p)) + 40'(m_ns) + 40'(m_ew) + 40'(m_a);
    s2_d.c   = s1_q.c;
  end

  hotspot_qmul #(.A_W(40), .B_W(32), .SHIFT(FLOAT_WIDTH)) u_mul_cap (
    .a(s2_q.sum), .b(CAP), .p(m_cap)
  );

  // Stage-3 result: centre plus scaled heat flow, clamped to 32 bits.
  always_comb begin
    out_d = '0;
    out_d = sat32(64'($signed(s2_q.c)) + 64'(m_cap));
  end

  // Pipeline registers; everything holds while the output is stalled.
  always_ff @(posedge aclk) begin
    if (!axi_resetn) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else if (adv) begin
      v1    <= join_ok;
      s1_q  <= s1_d;
      v2    <= v1;
      s2_q  <= s2_d;
      v3    <= v2;
      out_q <= out_d;
    end
  end

  // Output beat counter; tracks handshakes so last follows the presented beat.
  always_ff @(posedge aclk) begin
    if (!axi_resetn) begin
      cnt <= '0;
    end else if (v3 && m_axis_temp_ready) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign m_axis_temp_data  = out_q;
  assign m_axis_temp_valid = v3;
  assign m_axis_temp_last  = v3 & (cnt == CNT_LAST);

endmodule

// File: tb/tb_hotspot_update.sv
// Self-checking bench for hotspot_update: two parameterisations driven in lockstep,
// checked against a wide-integer reference of the HotSpot2D step.
`timescale 1ns/1ps
module tb_hotspot_update;

  localparam int unsigned SZ    = 4;
  localparam int unsigned FRAME = SZ * SZ;
  localparam logic [31:0] AMB_V = 32'h14000000;
  localparam logic [31:0] A_CAP = 32'h00400000;
  localparam logic [31:0] A_RX  = 32'h00000000;
  localparam logic [31:0] A_RY  = 32'h00200000;
  localparam logic [31:0] A_RZ  = 32'h00000000;
  localparam logic [31:0] B_CAP = 32'h00200000;
  localparam logic [31:0] B_RX  = 32'h00100000;
  localparam logic [31:0] B_RY  = 32'h00300000;
  localparam logic [31:0] B_RZ  = 32'h00080000;

  logic         aclk = 1'b0;
  logic         axi_resetn = 1'b0;
  logic [159:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic [31:0]  pdata = '0;
  logic         pvalid = 1'b0;
  logic         oready = 1'b0;

  logic        a_tready, a_pready, a_ovalid, a_olast;
  logic [31:0] a_odata;
  logic        b_tready, b_pready, b_ovalid, b_olast;
  logic [31:0] b_odata;

  always #5 aclk = ~aclk;

  hotspot_update #(
    .SIZE(SZ), .CAP(A_CAP), .RX_INV(A_RX), .RY_INV(A_RY), .RZ_INV(A_RZ), .AMB(AMB_V)
  ) u_dut_a (
    .aclk(aclk), .axi_resetn(axi_resetn),
    .s_axis_temp_data(tdata), .s_axis_temp_valid(tvalid), .s_axis_temp_ready(a_tready),
    .s_axis_power_data(pdata), .s_axis_power_valid(pvalid), .s_axis_power_ready(a_pready),
    .m_axis_temp_data(a_odata), .m_axis_temp_valid(a_ovalid),
    .m_axis_temp_ready(oready), .m_axis_temp_last(a_olast)
  );

  hotspot_update #(
    .SIZE(SZ), .CAP(B_CAP), .RX_INV(B_RX), .RY_INV(B_RY), .RZ_INV(B_RZ)
  ) u_dut_b (
    .aclk(aclk), .axi_resetn(axi_resetn),
    .s_axis_temp_data(tdata), .s_axis_temp_valid(tvalid), .s_axis_temp_ready(b_tready),
    .s_axis_power_data(pdata), .s_axis_power_valid(pvalid), .s_axis_power_ready(b_pready),
    .m_axis_temp_data(b_odata), .m_axis_temp_valid(b_ovalid),
    .m_axis_temp_ready(oready), .m_axis_temp_last(b_olast)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          lastpos[$];
  int          out_cnt = 0;
  int          joins = 0;
  logic        seen_out = 1'b0;
  logic [31:0] seen_a = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] sx(input logic [31:0] x);
    return 128'($signed(x));
  endfunction

  function automatic logic signed [127:0] q(input logic signed [127:0] a,
                                            input logic signed [127:0] b);
    return (a * b) >>> 22;
  endfunction

  // One explicit HotSpot2D step computed with wide integers.
  function automatic logic [31:0] ref_step(input logic [159:0] w, input logic [31:0] p,
                                           input logic [31:0] rx, input logic [31:0] ry,
                                           input logic [31:0] rz, input logic [31:0] cap);
    logic signed [127:0] c, n, s, we, e, t;
    logic signed [39:0]  s40;
    c  = sx(w[31:0]);
    n  = sx(w[63:32]);
    s  = sx(w[95:64]);
    we = sx(w[127:96]);
    e  = sx(w[159:128]);
    t  = sx(p) + q(n + s - 2 * c, sx(ry)) + q(we + e - 2 * c, sx(rx)) + q(sx(AMB_V) - c, sx(rz));
    s40 = t[39:0];
    t  = s40;
    t  = c + q(t, sx(cap));
    if (t > 128'sd2147483647) return 32'h7FFFFFFF;
    if (t < -128'sd2147483648) return 32'h80000000;
    return t[31:0];
  endfunction

  function automatic logic [159:0] mkwin(input logic [31:0] c, input logic [31:0] n,
                                         input logic [31:0] s, input logic [31:0] w,
                                         input logic [31:0] e);
    return {e, w, s, n, c};
  endfunction

  task automatic observe();
    logic exp_rdy;
    exp_rdy = axi_resetn & (~a_ovalid | oready) & tvalid & pvalid;
    chk1("tready", a_tready, exp_rdy);
    chk1("pready", a_pready, exp_rdy);
    chk1("b_tready", b_tready, exp_rdy);
    if (stall_prev) begin
      chk1("hold_valid", a_ovalid, 1'b1);
      chk32("hold_data", a_odata, stall_data);
      chk1("hold_last", a_olast, stall_last);
    end
    stall_prev = axi_resetn & a_ovalid & ~oready;
    stall_data = a_odata;
    stall_last = a_olast;
    seen_out = 1'b0;
    if (axi_resetn && tvalid && pvalid && a_tready) begin
      qa.push_back(ref_step(tdata, pdata, A_RX, A_RY, A_RZ, A_CAP));
      qb.push_back(ref_step(tdata, pdata, B_RX, B_RY, B_RZ, B_CAP));
      joins++;
    end
    if (axi_resetn && a_ovalid && oready) begin
      seen_out = 1'b1;
      seen_a   = a_odata;
      tests++;
      assert (qa.size() != 0) else begin
        fails++;
        $error("FAIL spurious_out observed=valid expected=no_pending_beat");
      end
      if (qa.size() != 0) begin
        chk32("data_a", a_odata, qa.pop_front());
        chk32("data_b", b_odata, qb.pop_front());
        chk1("valid_b", b_ovalid, 1'b1);
        chk1("last_a", a_olast, (out_cnt % FRAME) == FRAME - 1);
        chk1("last_b", b_olast, (out_cnt % FRAME) == FRAME - 1);
      end
      if (a_olast) lastpos.push_back(out_cnt);
      out_cnt++;
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    observe();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    lastpos.delete();
    out_cnt    = 0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    axi_resetn = 1'b0;
    repeat (ncyc) cycle();
    axi_resetn = 1'b1;
    clear_model();
  endtask

  task automatic rand_beat();
    tdata = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    pdata = $urandom();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    oready = 1'b1;
    tvalid = 1'b0;
    pvalid = 1'b0;
    while (qa.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    chk32(tag, qa.size(), 0);
  endtask

  // Single directed beat: checks value of design A and join-to-valid latency.
  task automatic one_beat(input string tag, input logic [159:0] w, input logic [31:0] p,
                          input logic [31:0] exp_a);
    int n, j0;
    logic got;
    tdata = w; pdata = p; tvalid = 1'b1; pvalid = 1'b1; oready = 1'b1;
    j0 = joins;
    n = 0;
    while (joins == j0 && n < 20) begin
      cycle();
      n++;
    end
    tvalid = 1'b0; pvalid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      cycle();
      n++;
      got = seen_out;
    end
    chk1({tag, "_seen"}, got, 1'b1);
    chk32(tag, seen_a, exp_a);
    chk32({tag, "_latency"}, 32'(n), 32'd3);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_i, last_i, outs, j0, sent, jp;

    // Reset with both inputs offering data: no ready, outputs cleared.
    tdata = mkwin(AMB_V, AMB_V, AMB_V, AMB_V, AMB_V);
    tvalid = 1'b1; pvalid = 1'b1; oready = 1'b1;
    do_reset(3);
    tvalid = 1'b0; pvalid = 1'b0;
    chk1("rst_valid", a_ovalid, 1'b0);
    chk1("rst_last", a_olast, 1'b0);
    chk32("rst_data", a_odata, 32'h0);
    chk32("rst_data_b", b_odata, 32'h0);

    // Directed values on design A (CAP=1.0, RY=0.5, RX=RZ=0).
    one_beat("ambient", mkwin(AMB_V, AMB_V, AMB_V, AMB_V, AMB_V), 32'h0, 32'h14000000);
    one_beat("power_step", mkwin(32'h02800000, 32'h02800000, 32'h02800000, 32'h02800000,
             32'h02800000), 32'h00400000, 32'h02C00000);
    one_beat("ns_flow", mkwin(32'h02800000, 32'h03000000, 32'h03000000, 32'h02800000,
             32'h02800000), 32'h0, 32'h03000000);
    one_beat("sat_hi", mkwin(32'h7D000000, 32'h7D000000, 32'h7D000000, 32'h7D000000,
             32'h7D000000), 32'h19000000, 32'h7FFFFFFF);
    one_beat("sat_lo", mkwin(32'h83000000, 32'h83000000, 32'h83000000, 32'h83000000,
             32'h83000000), 32'hE7000000, 32'h80000000);

    // Continuous stream: one output per cycle after three cycles.
    tdata = mkwin(AMB_V, AMB_V, AMB_V, AMB_V, AMB_V);
    pdata = '0;
    oready = 1'b1;
    j0 = joins; first_i = -1; last_i = -1; outs = 0;
    for (int i = 0; i < 14; i++) begin
      tvalid = (joins - j0) < 8;
      pvalid = (joins - j0) < 8;
      cycle();
      if (seen_out) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        outs++;
        chk32("stream_val", seen_a, 32'h14000000);
      end
    end
    chk32("stream_outs", 32'(outs), 32'd8);
    chk32("stream_first", 32'(first_i), 32'd3);
    chk32("stream_span", 32'(last_i - first_i + 1), 32'd8);

    // Power lags temperature by five cycles: nothing consumed until both valid.
    rand_beat();
    tvalid = 1'b1; pvalid = 1'b0;
    j0 = joins;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk1("lag_tready", a_tready, 1'b0);
      chk1("lag_pready", a_pready, 1'b0);
    end
    pvalid = 1'b1;
    cycle();
    tvalid = 1'b0; pvalid = 1'b0;
    chk32("lag_joins", 32'(joins - j0), 32'd1);
    drain("lag_drain");

    // Output stalled ten cycles mid-stream across 20 random beats.
    sent = 0; jp = joins;
    rand_beat();
    tvalid = 1'b0; pvalid = 1'b0;
    for (int i = 0; i < 300 && (sent < 20 || qa.size() != 0); i++) begin
      oready = !(i >= 6 && i < 16);
      if (sent < 20) begin
        if (!tvalid) tvalid = ($urandom_range(0, 3) != 0);
        if (!pvalid) pvalid = ($urandom_range(0, 3) != 0);
      end
      cycle();
      if (joins != jp) begin
        jp = joins;
        sent++;
        rand_beat();
        tvalid = 1'b0; pvalid = 1'b0;
      end
    end
    tvalid = 1'b0; pvalid = 1'b0;
    chk32("stall_sent", 32'(sent), 32'd20);
    chk32("stall_left", qa.size(), 0);

    // Frame marker with a reset after the seventh output.
    oready = 1'b1;
    do_reset(1);
    rand_beat();
    tvalid = 1'b1; pvalid = 1'b1;
    for (int i = 0; i < 50 && out_cnt < 7; i++) begin
      jp = joins;
      cycle();
      if (joins != jp) rand_beat();
    end
    chk32("pre_reset_outs", 32'(out_cnt), 32'd7);
    axi_resetn = 1'b0;
    cycle();
    axi_resetn = 1'b1;
    tvalid = 1'b0; pvalid = 1'b0;
    clear_model();
    chk1("mid_rst_valid", a_ovalid, 1'b0);
    chk1("mid_rst_last", a_olast, 1'b0);
    chk32("mid_rst_data", a_odata, 32'h0);

    sent = 0; jp = joins;
    rand_beat();
    for (int i = 0; i < 400 && (sent < 40 || qa.size() != 0); i++) begin
      oready = ($urandom_range(0, 4) != 0);
      tvalid = (sent < 40);
      pvalid = (sent < 40);
      cycle();
      if (joins != jp) begin
        jp = joins;
        sent++;
        rand_beat();
      end
    end
    tvalid = 1'b0; pvalid = 1'b0;
    chk32("frame_outs", 32'(out_cnt), 32'd40);
    chk32("last_count", lastpos.size(), 2);
    if (lastpos.size() >= 2) begin
      chk32("last_first", 32'(lastpos[0]), 32'd15);
      chk32("last_second", 32'(lastpos[1]), 32'd31);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hotspot_update.md
Name: hotspot_update

Overview:
- Consumer at the far end of the stencil-window producer. Joins the 5-point temperature window stream with the matching power stream.
- Computes one explicit HotSpot2D time step per cell in Q10.22 fixed point and emits one updated temperature per window.
- Output is a single 32-bit AXI-Stream with a frame-end marker, sent to the write-back DMA.

Parameters:
- DATA_WIDTH, 32, word width; all arithmetic assumes 32.
- INT_WIDTH, 10, integer bits (sign included) of Q format.
- FLOAT_WIDTH, 22, fractional bits of Q format.
- SIZE, 512, grid edge length; one frame is SIZE*SIZE outputs.
- CAP, 32'h00400000, step/capacitance coefficient (Q10.22).
- RX_INV, 32'h00000000, 1/Rx coefficient (Q10.22).
- RY_INV, 32'h00000000, 1/Ry coefficient (Q10.22).
- RZ_INV, 32'h00000000, 1/Rz coefficient (Q10.22).
- AMB, 32'h14000000, ambient temperature, 80.0 (Q10.22).

Ports:
- aclk  in  1  clock
- axi_resetn  in  1  synchronous active-low reset
- s_axis_temp_data  in  DATA_WIDTH*5  window: [31:0]=C, [63:32]=N, [95:64]=S, [127:96]=W, [159:128]=E
- s_axis_temp_valid  in  1  window valid
- s_axis_temp_ready  out  1  window accepted
- s_axis_power_data  in  DATA_WIDTH  power P of center cell (Q10.22)
- s_axis_power_valid  in  1  power valid
- s_axis_power_ready  out  1  power accepted
- m_axis_temp_data  out  DATA_WIDTH  updated temperature (Q10.22)
- m_axis_temp_valid  out  1  output valid
- m_axis_temp_ready  in  1  downstream ready
- m_axis_temp_last  out  1  high on last cell of a frame

Behaviour:
- Reset, sampled on aclk edge with axi_resetn=0:
  - All stage valids clear; m_axis_temp_valid=0, m_axis_temp_last=0, m_axis_temp_data=0.
  - Output counter clears to 0; both s_*_ready=0 during reset.
  - Reset mid-frame discards in-flight data; the counter restarts at 0.
- Pipeline advance: adv = ~v3 | m_axis_temp_ready, where v3 is the stage-3 valid. All stages shift together on adv (stall-all).
- Join rule:
  - s_axis_temp_ready = s_axis_power_ready = adv & s_axis_temp_valid & s_axis_power_valid.
  - A beat is consumed from both inputs or from neither; one input is never consumed alone.
- Latency: 3 cycles from join to m_axis_temp_valid when not stalled. Throughput is 1 per cycle.
- Stage 1:
  - dNS = N+S-2C, dEW = W+E-2C (34-bit signed).
  - dA = AMB-C (33-bit signed).
  - Register C and P alongside.
- Stage 2:
  - sum = P + mul(dNS,RY_INV) + mul(dEW,RX_INV) + mul(dA,RZ_INV), 40-bit signed.
  - mul(a,b) = full signed product, arithmetic shift right by FLOAT_WIDTH (truncate toward -inf).
- Stage 3:
  - out = sat32(C + mul(sum,CAP)).
  - sat32 clamps to 32'h7FFFFFFF / 32'h80000000.
- Output hold: while m_axis_temp_valid=1 and m_axis_temp_ready=0, data, last and valid stay stable.
- Counter and last:
  - The counter increments on each output handshake.
  - m_axis_temp_last=1 when the counter value of the presented beat equals SIZE*SIZE-1.
  - On that handshake the counter wraps to 0.
  - The counter is attached to the output beat, not the input.
- Simultaneous output handshake and new join in the same cycle: both happen; no bubble.

Decomposition:
- Shared package hotspot_pkg holds:
  - Q-format constants (INT_WIDTH, FLOAT_WIDTH, ONE = 1<<FLOAT_WIDTH).
  - Window lane index constants (LANE_C/N/S/W/E).
  - Saturation bounds.
  - The fixed-point mul/sat functions.
- One natural sub-module: hotspot_qmul, a parameterized signed multiply-and-shift, instantiated 4 times.

Test Plan:
- Defaults, all five lanes = 32'h14000000, P=0, streamed continuously -> every output 32'h14000000; one output per cycle after 3-cycle latency.
- CAP=1.0, RX/RY/RZ=0, C=10.0 (32'h02800000), P=1.0 -> output 32'h02C00000 (11.0).
- CAP=1.0, RY_INV=0.5, C=10.0, N=S=12.0, others=C, P=0 -> 12.0 (32'h03000000).
- Saturation: C=500.0, CAP=1.0, P=100.0 -> 32'h7FFFFFFF; C=-500.0, P=-100.0 -> 32'h80000000.
- Handshake stress:
  - Power valid lags temp valid by 5 cycles -> both ready stay 0 until both are valid; single joint consume.
  - m_axis_temp_ready low 10 cycles mid-stream -> stable output, no loss or reorder across 20 random beats.
- SIZE=4 -> last on outputs 16 and 32 only. axi_resetn pulsed low after output 7 -> valid drops next cycle; after restart, last falls on the 16th new output.
